// File: rtl/ripple_count_monitor.sv
// Consumer of an asynchronous mod-MOD ripple counter: synchronizes and de-glitches the
// count bus, then tracks legal steps/wraps and flags sequence or range errors.
module ripple_count_monitor #(
    parameter int CNT_W      = 4,
    parameter int MOD        = 8,
    parameter int STABLE_CYC = 2,
    parameter int WRAP_W     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CNT_W-1:0]  count_in,
    input  logic              clr,
    output logic [CNT_W-1:0]  count_q,
    output logic              count_valid,
    output logic              step_pulse,
    output logic              wrap_pulse,
    output logic [WRAP_W-1:0] wrap_cnt,
    output logic              err_skip,
    output logic              err_range
);

    localparam int                STAB_W    = $clog2(STABLE_CYC + 1);
    localparam logic [STAB_W-1:0] STAB_MAX  = STAB_W'(STABLE_CYC);
    localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_CYC - 1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(MOD - 1);
    localparam logic [CNT_W:0]    MOD_EXT   = (CNT_W + 1)'(MOD);

    typedef enum logic [1:0] {
        ST_INIT,
        ST_TRACK,
        ST_FAULT
    } state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_s1;
    logic [CNT_W-1:0]  r_s2;
    logic [CNT_W-1:0]  r_cand;
    logic [STAB_W-1:0] r_stab;

    logic              w_accept;
    logic              w_in_range;
    logic [CNT_W-1:0]  w_succ;

    // Two-flop synchronizer; deliberately untouched by clr.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= count_in;
            r_s2 <= r_s1;
        end
    end

    // The candidate follows the value entering s2, so a stable run is counted
    // from the first clock the synchronized bus shows it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cand <= '0;
            r_stab <= '0;
        end else if (clr) begin
            r_cand <= '0;
            r_stab <= '0;
        end else if (r_s1 != r_cand) begin
            r_cand <= r_s1;
            r_stab <= '0;
        end else if (r_stab < STAB_MAX) begin
            r_stab <= r_stab + 1'b1;
        end
    end

    assign w_accept   = (r_s1 == r_cand) && (r_s2 == r_cand) && (r_stab == STAB_LAST);
    assign w_in_range = ({1'b0, r_cand} < MOD_EXT);
    assign w_succ     = (count_q == CNT_LAST) ? '0 : count_q + 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_INIT;
            count_q     <= '0;
            count_valid <= 1'b0;
            step_pulse  <= 1'b0;
            wrap_pulse  <= 1'b0;
            wrap_cnt    <= '0;
            err_skip    <= 1'b0;
            err_range   <= 1'b0;
        end else begin
            step_pulse <= 1'b0;
            wrap_pulse <= 1'b0;
            if (clr) begin
                r_state     <= ST_INIT;
                count_q     <= '0;
                count_valid <= 1'b0;
                wrap_cnt    <= '0;
                err_skip    <= 1'b0;
                err_range   <= 1'b0;
            end else if (w_accept) begin
                case (r_state)
                    ST_INIT: begin
                        if (!w_in_range) begin
                            err_range <= 1'b1;
                            r_state   <= ST_FAULT;
                        end else begin
                            count_q     <= r_cand;
                            count_valid <= 1'b1;
                            r_state     <= ST_TRACK;
                        end
                    end
                    ST_TRACK: begin
                        if (r_cand == count_q) begin
                            // re-acceptance after a filtered glitch: nothing changed
                        end else if (!w_in_range) begin
                            err_range <= 1'b1;
                            r_state   <= ST_FAULT;
                        end else if (r_cand == w_succ) begin
                            count_q    <= r_cand;
                            step_pulse <= 1'b1;
                            if (r_cand == '0) begin
                                wrap_pulse <= 1'b1;
                                if (wrap_cnt != '1) begin
                                    wrap_cnt <= wrap_cnt + 1'b1;
                                end
                            end
                        end else if (r_cand == '0) begin
                            // upstream counter was reset
                            count_q <= '0;
                        end else begin
                            err_skip <= 1'b1;
                            count_q  <= r_cand;
                        end
                    end
                    default: begin
                        // FAULT ignores acceptances until clr or rst
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ripple_count_monitor.sv
// Bench for ripple_count_monitor: directed scenarios plus randomized counter activity,
// compared every clock against a sample-history reference model.
module tb_ripple_count_monitor;

    localparam int CNT_W      = 4;
    localparam int MOD        = 8;
    localparam int STABLE_CYC = 2;
    localparam int WRAP_W     = 8;

    logic              clk      = 1'b0;
    logic              rst      = 1'b0;
    logic              clr      = 1'b0;
    logic [CNT_W-1:0]  count_in = '0;
    logic [CNT_W-1:0]  count_q;
    logic              count_valid;
    logic              step_pulse;
    logic              wrap_pulse;
    logic [WRAP_W-1:0] wrap_cnt;
    logic              err_skip;
    logic              err_range;

    ripple_count_monitor #(
        .CNT_W     (CNT_W),
        .MOD       (MOD),
        .STABLE_CYC(STABLE_CYC),
        .WRAP_W    (WRAP_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .count_in   (count_in),
        .clr        (clr),
        .count_q    (count_q),
        .count_valid(count_valid),
        .step_pulse (step_pulse),
        .wrap_pulse (wrap_pulse),
        .wrap_cnt   (wrap_cnt),
        .err_skip   (err_skip),
        .err_range  (err_range)
    );

    always #5 clk = ~clk;

    int n_vec      = 0;
    int n_bad      = 0;
    int obs_steps  = 0;
    int obs_wraps  = 0;

    // Reference model: samples delayed by one clock into the run tracker,
    // run length counted in synchronized clocks, spec rules applied on acceptance.
    int         dly[$];
    int         run_val;
    int         run_len;
    int         m_mode;   // 0 = INIT, 1 = TRACK, 2 = FAULT
    logic [3:0] m_q;
    logic       m_valid, m_step, m_wrap, m_skip, m_range;
    logic [7:0] m_wraps;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void m_reset();
        dly.delete();
        dly.push_back(0);
        run_val = 0;
        run_len = 1;
        m_mode  = 0;
        m_q     = '0;
        m_valid = 1'b0;
        m_step  = 1'b0;
        m_wrap  = 1'b0;
        m_skip  = 1'b0;
        m_range = 1'b0;
        m_wraps = '0;
    endfunction

    function automatic void m_apply(int v);
        if (m_mode == 0) begin
            if (v >= MOD) begin
                m_range = 1'b1;
                m_mode  = 2;
            end else begin
                m_q     = 4'(v);
                m_valid = 1'b1;
                m_mode  = 1;
            end
        end else if (m_mode == 1) begin
            if (v == int'(m_q)) begin
                m_mode = 1;
            end else if (v >= MOD) begin
                m_range = 1'b1;
                m_mode  = 2;
            end else if (v == (int'(m_q) + 1) % MOD) begin
                m_q    = 4'(v);
                m_step = 1'b1;
                if (v == 0) begin
                    m_wrap = 1'b1;
                    if (m_wraps != 8'hFF) m_wraps = m_wraps + 8'd1;
                end
            end else if (v == 0) begin
                m_q = '0;
            end else begin
                m_skip = 1'b1;
                m_q    = 4'(v);
            end
        end
    endfunction

    function automatic void m_edge(int x, bit c);
        int e;
        e = dly.pop_front();
        dly.push_back(x);
        if (e == run_val) run_len++;
        else begin
            run_val = e;
            run_len = 1;
        end
        m_step = 1'b0;
        m_wrap = 1'b0;
        if (c) begin
            m_mode  = 0;
            m_q     = '0;
            m_valid = 1'b0;
            m_skip  = 1'b0;
            m_range = 1'b0;
            m_wraps = '0;
            run_val = 0;
            run_len = 1;
        end else if (run_len == STABLE_CYC + 1) begin
            m_apply(e);
        end
    endfunction

    function automatic logic [31:0] obs_word();
        return {15'd0, count_q, count_valid, step_pulse, wrap_pulse, wrap_cnt, err_skip, err_range};
    endfunction

    function automatic logic [31:0] exp_word();
        return {15'd0, m_q, m_valid, m_step, m_wrap, m_wraps, m_skip, m_range};
    endfunction

    task automatic step(input logic [3:0] v, input bit c, input bit r);
        @(negedge clk);
        count_in = v;
        clr      = c;
        rst      = r;
        @(posedge clk);
        if (!r) m_reset();
        else    m_edge(int'(v), c);
        #1;
        check_val("cycle", obs_word(), exp_word());
        if (step_pulse) obs_steps++;
        if (wrap_pulse) obs_wraps++;
    endtask

    task automatic hold(input logic [3:0] v, input int n);
        repeat (n) step(v, 1'b0, 1'b1);
    endtask

    initial begin
        int cur;
        int nxt;
        int rv;
        m_reset();

        // 1: reset then a full count cycle with one wrap
        #1;
        check_val("reset_state", obs_word(), 32'd0);
        step(4'd0, 1'b0, 1'b0);
        step(4'd0, 1'b0, 1'b0);
        hold(4'd0, 8);
        obs_steps = 0;
        obs_wraps = 0;
        for (int i = 1; i <= 9; i++) hold(4'(i % MOD), 8);
        check_val("t1_steps", 32'(obs_steps), 32'd9);
        check_val("t1_wraps", 32'(obs_wraps), 32'd1);
        check_val("t1_wrap_cnt", 32'(wrap_cnt), 32'd1);
        check_val("t1_errs", {30'd0, err_skip, err_range}, 32'd0);
        check_val("t1_count_q", 32'(count_q), 32'd1);
        $display("phase 1 done: steps=%0d wraps=%0d", obs_steps, obs_wraps);

        // 2: one-clock glitch must be filtered
        hold(4'd2, 8);
        hold(4'd3, 8);
        obs_steps = 0;
        hold(4'd2, 1);
        hold(4'd3, 6);
        hold(4'd4, 8);
        check_val("t2_steps", 32'(obs_steps), 32'd1);
        check_val("t2_count_q", 32'(count_q), 32'd4);
        check_val("t2_err_skip", 32'(err_skip), 32'd0);
        $display("phase 2 done: count_q=%0d", count_q);

        // 3: upstream restart, then a skip
        hold(4'd5, 8);
        obs_steps = 0;
        hold(4'd0, 8);
        check_val("t3_restart_q", 32'(count_q), 32'd0);
        check_val("t3_restart_pulse", 32'(obs_steps), 32'd0);
        check_val("t3_restart_err", 32'(err_skip), 32'd0);
        hold(4'd2, 8);
        check_val("t3_skip_err", 32'(err_skip), 32'd1);
        check_val("t3_skip_q", 32'(count_q), 32'd2);
        hold(4'd3, 8);
        check_val("t3_skip_sticky", 32'(err_skip), 32'd1);
        $display("phase 3 done: count_q=%0d", count_q);

        // 4: out-of-range value, FAULT, clr recovery
        hold(4'd9, 8);
        check_val("t4_range", 32'(err_range), 32'd1);
        obs_steps = 0;
        hold(4'd4, 8);
        hold(4'd5, 8);
        check_val("t4_fault_q", 32'(count_q), 32'd3);
        check_val("t4_fault_steps", 32'(obs_steps), 32'd0);
        step(4'd5, 1'b1, 1'b1);
        check_val("t4_clr", obs_word(), 32'd0);
        hold(4'd5, 8);
        check_val("t4_reaccept_q", 32'(count_q), 32'd5);
        check_val("t4_reaccept_valid", 32'(count_valid), 32'd1);
        check_val("t4_reaccept_range", 32'(err_range), 32'd0);
        $display("phase 4 done: count_q=%0d", count_q);

        // 5: wrap tally saturation
        step(4'd0, 1'b1, 1'b1);
        hold(4'd0, 8);
        obs_wraps = 0;
        for (int w = 0; w < 256; w++) begin
            for (int k = 1; k <= MOD; k++) hold(4'(k % MOD), 4);
            if (w == 254) check_val("t5_wrap_255", 32'(wrap_cnt), 32'd255);
        end
        check_val("t5_wrap_sat", 32'(wrap_cnt), 32'd255);
        check_val("t5_wrap_pulses", 32'(obs_wraps), 32'd256);
        $display("phase 5 done: wrap_cnt=%0d pulses=%0d", wrap_cnt, obs_wraps);

        // 6: asynchronous reset mid-sequence
        step(4'd0, 1'b1, 1'b1);
        for (int k = 0; k <= 6; k++) hold(4'(k), 5);
        check_val("t6_pre_q", 32'(count_q), 32'd6);
        #2;
        rst = 1'b0;
        #1;
        check_val("t6_async_rst", obs_word(), 32'd0);
        m_reset();
        step(4'd6, 1'b0, 1'b0);
        step(4'd6, 1'b0, 1'b0);
        hold(4'd6, 8);
        check_val("t6_first_q", 32'(count_q), 32'd6);
        check_val("t6_first_valid", 32'(count_valid), 32'd1);
        check_val("t6_first_errs", {30'd0, err_skip, err_range}, 32'd0);
        $display("phase 6 done: count_q=%0d", count_q);

        // random counter activity: steps, restarts, glitches, jumps, out-of-range, clr
        cur = 6;
        for (int it = 0; it < 500; it++) begin
            rv = int'($urandom_range(0, 99));
            if (rv < 55)      nxt = (cur + 1) % MOD;
            else if (rv < 65) nxt = 0;
            else if (rv < 75) nxt = cur;
            else if (rv < 85) begin
                hold(4'($urandom_range(0, 15)), 1);
                nxt = cur;
            end
            else if (rv < 95) nxt = int'($urandom_range(0, MOD - 1));
            else              nxt = int'($urandom_range(MOD, 15));
            if ($urandom_range(0, 24) == 0) step(4'(nxt), 1'b1, 1'b1);
            hold(4'(nxt), int'($urandom_range(1, 6)));
            cur = (nxt < MOD) ? nxt : cur;
        end
        $display("random phase done");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
